// File: rtl/mod_div_unit_if.sv
// Handshake and result bundle between the CPU execute stage and mod_div_unit.
// The CPU drives the master side and the divider drives the slave side.
interface mod_div_unit_if #(
  parameter int WIDTH = 16
);
  logic             Start;
  logic [WIDTH-1:0] Hyrja1;
  logic [WIDTH-1:0] Hyrja2;
  logic [WIDTH-1:0] Quotient;
  logic [WIDTH-1:0] Dalja;
  logic             Busy;
  logic             Done;
  logic             DivByZero;

  modport master (
    output Start, Hyrja1, Hyrja2,
    input  Quotient, Dalja, Busy, Done, DivByZero
  );

  modport slave (
    input  Start, Hyrja1, Hyrja2,
    output Quotient, Dalja, Busy, Done, DivByZero
  );
endinterface

// File: rtl/mod_div_unit.sv
// Multi-cycle restoring divider, one quotient bit per clock, with Start/Done handshake.
// Define MOD_DIV_SIGNED_EN for two's-complement operands (adds one sign fix-up cycle).
module mod_div_unit #(
  parameter int WIDTH = 16
) (
  input  logic         Clock,
  input  logic         Reset,
  mod_div_unit_if.slave divIf
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {IDLE, CALC, FIX, ZERO, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, rem_q, rem_d;
  logic [WIDTH-1:0] quot_q, quot_d, dalja_q, dalja_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dbz_q, dbz_d;
`ifdef MOD_DIV_SIGNED_EN
  logic             negQ_q, negQ_d, negR_q, negR_d;
`endif

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] stepA, stepR;

  // The partial remainder is widened by one bit so divisors >= 2^(WIDTH-1) cannot overflow.
  always_comb begin
    shifted = {rem_q, a_q[WIDTH-1]};
    if (shifted >= {1'b0, b_q}) begin
      stepR = WIDTH'(shifted - {1'b0, b_q});
      stepA = {a_q[WIDTH-2:0], 1'b1};
    end else begin
      stepR = shifted[WIDTH-1:0];
      stepA = {a_q[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    dalja_d = dalja_q;
    dbz_d   = dbz_q;
`ifdef MOD_DIV_SIGNED_EN
    negQ_d  = negQ_q;
    negR_d  = negR_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (divIf.Start) begin
          rem_d = '0;
          cnt_d = '0;
          dbz_d = 1'b0;
          if (divIf.Hyrja2 == '0) begin
            state_d = ZERO;
            a_d     = divIf.Hyrja1;
            b_d     = '0;
          end else begin
            state_d = CALC;
`ifdef MOD_DIV_SIGNED_EN
            a_d    = divIf.Hyrja1[WIDTH-1] ? -divIf.Hyrja1 : divIf.Hyrja1;
            b_d    = divIf.Hyrja2[WIDTH-1] ? -divIf.Hyrja2 : divIf.Hyrja2;
            negQ_d = divIf.Hyrja1[WIDTH-1] ^ divIf.Hyrja2[WIDTH-1];
            negR_d = divIf.Hyrja1[WIDTH-1];
`else
            a_d    = divIf.Hyrja1;
            b_d    = divIf.Hyrja2;
`endif
          end
        end
      end
      CALC: begin
        a_d   = stepA;
        rem_d = stepR;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1)) begin
          cnt_d = '0;
`ifdef MOD_DIV_SIGNED_EN
          state_d = FIX;
`else
          state_d = DONE;
          quot_d  = stepA;
          dalja_d = stepR;
`endif
        end
      end
`ifdef MOD_DIV_SIGNED_EN
      // MIN / -1 falls out naturally: magnitude 2^(WIDTH-1) with positive sign is MIN again.
      FIX: begin
        state_d = DONE;
        quot_d  = negQ_q ? -a_q : a_q;
        dalja_d = negR_q ? -rem_q : rem_q;
      end
`endif
      ZERO: begin
        state_d = DONE;
        quot_d  = '1;
        dalja_d = a_q;
        dbz_d   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      dalja_q <= '0;
      dbz_q   <= 1'b0;
`ifdef MOD_DIV_SIGNED_EN
      negQ_q  <= 1'b0;
      negR_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      dalja_q <= dalja_d;
      dbz_q   <= dbz_d;
`ifdef MOD_DIV_SIGNED_EN
      negQ_q  <= negQ_d;
      negR_q  <= negR_d;
`endif
    end
  end

  assign divIf.Quotient  = quot_q;
  assign divIf.Dalja     = dalja_q;
  assign divIf.DivByZero = dbz_q;
  assign divIf.Done      = (state_q == DONE);
  assign divIf.Busy      = (state_q == CALC) || (state_q == FIX);
endmodule

// File: tb/tb_mod_div_unit.sv
// Scoreboard bench for mod_div_unit (WIDTH=16); expected results queued at drive time.
// Build with MOD_DIV_SIGNED_EN defined to exercise the signed variant.
module tb_mod_div_unit;
  localparam int WIDTH = 16;

  typedef struct {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dbz;
    int               lat;
    int               busy;
    int               cyc;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cycleCnt = 0;
  int   busyCnt = 0;
  int   vecCount = 0;
  int   missCount = 0;
  exp_t sb[$];

  mod_div_unit_if #(.WIDTH(WIDTH)) divIf();

  mod_div_unit #(.WIDTH(WIDTH)) dut (
    .Clock(clock),
    .Reset(reset),
    .divIf(divIf)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecCount++;
    if (obs !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int cyc);
    exp_t e;
    e.cyc = cyc;
    if (b == '0) begin
      e.q = '1; e.r = a; e.dbz = 1'b1; e.lat = 1; e.busy = 0;
    end else begin
      e.dbz = 1'b0;
`ifdef MOD_DIV_SIGNED_EN
      if (a == 16'h8000 && b == 16'hFFFF) begin
        e.q = 16'h8000; e.r = '0;
      end else begin
        e.q = $signed(a) / $signed(b);
        e.r = $signed(a) % $signed(b);
      end
      e.lat = WIDTH + 1; e.busy = WIDTH + 1;
`else
      e.q = a / b; e.r = a % b;
      e.lat = WIDTH; e.busy = WIDTH;
`endif
    end
    return e;
  endfunction

  // Pops one expectation per Done pulse; latency is counted from the accepting edge.
  initial begin
    forever begin
      @(negedge clock);
      if (divIf.Done) begin
        if (sb.size() == 0) begin
          checkOutput("unexpectedDone", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("quotient", 32'(divIf.Quotient), 32'(e.q));
          checkOutput("remainder", 32'(divIf.Dalja), 32'(e.r));
          checkOutput("divByZero", 32'(divIf.DivByZero), 32'(e.dbz));
          checkOutput("latency", 32'(cycleCnt - e.cyc - 1), 32'(e.lat));
          checkOutput("busyCycles", 32'(busyCnt), 32'(e.busy));
        end
        busyCnt = 0;
      end else if (divIf.Busy) begin
        busyCnt++;
      end
    end
  end

  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit hold);
    divIf.Start  = 1'b1;
    divIf.Hyrja1 = a;
    divIf.Hyrja2 = b;
    sb.push_back(model(a, b, cycleCnt));
    @(posedge clock);
    @(negedge clock);
    if (!hold) divIf.Start = 1'b0;
  endtask

  task automatic waitIdle();
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checkOutput("idleTimeout", 32'd0, 32'd1);
      sb.delete();
    end
  endtask

  task automatic waitDone();
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (divIf.Done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) checkOutput("doneTimeout", 32'd0, 32'd1);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "Quotient"}, 32'(divIf.Quotient), 32'd0);
    checkOutput({tag, "Dalja"}, 32'(divIf.Dalja), 32'd0);
    checkOutput({tag, "Busy"}, 32'(divIf.Busy), 32'd0);
    checkOutput({tag, "Done"}, 32'(divIf.Done), 32'd0);
    checkOutput({tag, "DivByZero"}, 32'(divIf.DivByZero), 32'd0);
  endtask

  initial begin
    divIf.Start  = 1'b0;
    divIf.Hyrja1 = '0;
    divIf.Hyrja2 = '0;
    repeat (2) @(negedge clock);
    checkAllZero("reset");
    reset = 1'b0;
    @(negedge clock);

    $display("[TB] basic division and divide by zero");
    applyStimulus(16'd100, 16'd7, 1'b0);
    waitIdle();
    applyStimulus(16'd5, 16'd0, 1'b0);
    waitIdle();

    $display("[TB] back-to-back accept in the Done cycle");
    applyStimulus(16'd3, 16'd10, 1'b0);
    waitDone();
    applyStimulus(16'hFFFF, 16'h8001, 1'b0);
    waitIdle();

    $display("[TB] Start while busy is ignored");
    applyStimulus(16'd40, 16'd6, 1'b1);
    repeat (3) @(negedge clock);
    divIf.Hyrja1 = 16'd9;
    divIf.Hyrja2 = 16'd9;
    repeat (5) @(negedge clock);
    divIf.Start = 1'b0;
    waitIdle();
    repeat (20) @(negedge clock);

    $display("[TB] reset mid-operation");
    applyStimulus(16'd1000, 16'd3, 1'b0);
    repeat (6) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    sb.delete();
    busyCnt = 0;
    checkAllZero("midReset");
    reset = 1'b0;
    repeat (2) @(negedge clock);
    checkOutput("noDoneAfterReset", 32'(divIf.Done), 32'd0);
    applyStimulus(16'd1000, 16'd3, 1'b0);
    waitIdle();

    $display("[TB] large divisors and random operands");
    applyStimulus(16'hFFFF, 16'hFFFF, 1'b0);
    waitIdle();
    applyStimulus(16'd0, 16'd77, 1'b0);
    waitIdle();
    for (int i = 0; i < 6; i++) begin
      logic [WIDTH-1:0] a, b;
      a = WIDTH'($urandom);
      case (i % 3)
        0:       b = WIDTH'($urandom_range(65535, 32768));
        1:       b = WIDTH'($urandom_range(300, 1));
        default: b = WIDTH'($urandom);
      endcase
      applyStimulus(a, b, 1'b0);
      waitIdle();
    end

`ifdef MOD_DIV_SIGNED_EN
    $display("[TB] signed operands");
    applyStimulus(16'hFFF9, 16'd2, 1'b0);
    waitIdle();
    applyStimulus(16'h8000, 16'hFFFF, 1'b0);
    waitIdle();
    applyStimulus(16'd7, 16'hFFFE, 1'b0);
    waitIdle();
    applyStimulus(16'hFFF9, 16'd0, 1'b0);
    waitIdle();
`endif

    repeat (5) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end
endmodule
